// File: rtl/mem_pkg.sv
`default_nettype none
// ==========================================================================
// mem_pkg : shared types and defaults for the data-memory arbiter
// Revision: 1.0
// ==========================================================================
package mem_pkg;

  localparam int W_DEF        = 8;
  localparam int A_DEF        = 8;
  localparam int MAXBURST_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  typedef logic [A_DEF-1:0] addr_t;
  typedef logic [W_DEF-1:0] data_t;

endpackage
`default_nettype wire

// File: rtl/mem_rd_ret.sv
`default_nettype none
// ==========================================================================
// mem_rd_ret : per-port read-return register (one-cycle Rvalid, held Rdata)
// Revision: 1.0
// ==========================================================================
module mem_rd_ret
  import mem_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Capture,
  input  logic [W-1:0] MemData,
  output logic         Rvalid,
  output logic [W-1:0] Rdata
);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Rvalid <= 1'b0;
      Rdata  <= '0;
    end else begin
      Rvalid <= Capture;
      if (Capture) begin
        Rdata <= MemData;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ==========================================================================
// mem_arbiter : two-port round-robin arbiter with capped locked bursts
// Revision: 1.0
// ==========================================================================
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int A        = A_DEF,
  parameter int MAXBURST = MAXBURST_DEF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Req0,
  input  logic         We0,
  input  logic         Lock0,
  input  logic [A-1:0] Addr0,
  input  logic [W-1:0] Wdata0,
  output logic         Gnt0,
  output logic         Rvalid0,
  output logic [W-1:0] Rdata0,
  input  logic         Req1,
  input  logic         We1,
  input  logic         Lock1,
  input  logic [A-1:0] Addr1,
  input  logic [W-1:0] Wdata1,
  output logic         Gnt1,
  output logic         Rvalid1,
  output logic [W-1:0] Rdata1,
  output logic         MemWriteEn,
  output logic [A-1:0] MemAddr,
  output logic [W-1:0] MemDataIn,
  input  logic [W-1:0] MemDataOut
);

  localparam int CW = $clog2(MAXBURST + 1);
  localparam logic [CW-1:0] c_max = CW'(MAXBURST);

  own_t          r_own, w_own_nxt;
  logic          r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_pick0, w_pick1;
  logic          w_lock, w_cont;
  logic [CW-1:0] w_beats;

  // Owner keeps the port while requesting; otherwise round-robin on Last.
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    if (r_own == OWN0 && Req0) begin
      w_pick0 = 1'b1;
    end else if (r_own == OWN1 && Req1) begin
      w_pick1 = 1'b1;
    end else if (Req0 && Req1) begin
      w_pick0 = r_last;
      w_pick1 = ~r_last;
    end else begin
      w_pick0 = Req0;
      w_pick1 = Req1;
    end
  end

  assign Gnt0 = w_pick0 & Reset;
  assign Gnt1 = w_pick1 & Reset;

  always_comb begin
    w_own_nxt  = IDLE;
    w_last_nxt = r_last;
    w_cnt_nxt  = '0;
    w_lock     = 1'b0;
    w_cont     = 1'b0;
    w_beats    = '0;
    if (Gnt0 || Gnt1) begin
      w_last_nxt = Gnt1;
      w_lock     = Gnt1 ? Lock1 : Lock0;
      w_cont     = (Gnt0 && r_own == OWN0) || (Gnt1 && r_own == OWN1);
      w_beats    = w_cont ? r_cnt + CW'(1) : CW'(1);
      // Reaching the cap releases ownership even with Lock held.
      if (w_lock && (w_beats < c_max)) begin
        w_own_nxt = Gnt1 ? OWN1 : OWN0;
        w_cnt_nxt = w_beats;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_own  <= IDLE;
      r_last <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_own  <= w_own_nxt;
      r_last <= w_last_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  always_comb begin
    MemWriteEn = 1'b0;
    MemAddr    = '0;
    MemDataIn  = '0;
    if (Gnt0) begin
      MemWriteEn = We0;
      MemAddr    = Addr0;
      MemDataIn  = Wdata0;
    end else if (Gnt1) begin
      MemWriteEn = We1;
      MemAddr    = Addr1;
      MemDataIn  = Wdata1;
    end
  end

  mem_rd_ret #(.W(W)) u_ret0 (
    .Clk     (Clk),
    .Reset   (Reset),
    .Capture (Gnt0 & ~We0),
    .MemData (MemDataOut),
    .Rvalid  (Rvalid0),
    .Rdata   (Rdata0)
  );

  mem_rd_ret #(.W(W)) u_ret1 (
    .Clk     (Clk),
    .Reset   (Reset),
    .Capture (Gnt1 & ~We1),
    .MemData (MemDataOut),
    .Rvalid  (Rvalid1),
    .Rdata   (Rdata1)
  );

endmodule
`default_nettype wire
